approx_adder_pipe: RTL and testbench
====================================

// Module: approx_adder_pipe
// PURPOSE
// Two-stage pipelined approximate adder. The low part uses the fixed-ones / OR-chain
// approximate scheme; the high part is exact. The approximation depth is selectable
// per transaction at run time. Operands and results use a valid/ready stream interface.
// Used as the arithmetic core in error-tolerant datapaths.
// PARAMETERS
// WIDTH     16  operand width; sum is WIDTH+1 bits
// APX_MAX   8   max approximate LSBs (1..WIDTH-1); apx_k values above this are clamped
// KW        4   width of apx_k; must satisfy 2**KW > APX_MAX
// ERR_CNT_W 16  width of error-monitor counters (ERR_MON_EN only)
// PORTS
// clk        in   1        clock, rising edge
// rst        in   1        asynchronous, active-high reset
// in_valid   in   1        operand beat valid
// in_ready   out  1        block can accept a beat this cycle
// in_a       in   WIDTH    operand A
// in_b       in   WIDTH    operand B
// apx_k      in   KW       approximate LSB count K for this beat (0 = exact)
// out_valid  out  1        result valid
// out_ready  in   1        downstream accepts result
// out_sum    out  WIDTH+1  result
// err_clr    in   1        synchronous clear of monitor counters
// err_cnt    out  ERR_CNT_W  number of delivered results with sum != exact
// err_acc    out  ERR_CNT_W  saturating sum of |exact - sum| over delivered results
// BEHAVIOUR
// - Reset (async assert): all valids 0, out_sum 0, err_cnt 0, err_acc 0; in-flight beats dropped.
// - Accept: a beat is accepted when in_valid & in_ready. apx_k is sampled with it.
//   K = min(apx_k, APX_MAX). F = K>>1.
// - Low part, bits i<K:
//   - i<F: s[i]=1.
//   - F<=i<K-1: s[i]=a[i]|b[i]|c[i], with c[F]=0 and c[i+1]=a[i]&b[i].
//   - i=K-1: s[i]=c[i]|(a[i]^b[i]); c[K-1]=0 when K-1==F.
//   - Carry into high part: ci = a[K-1]&b[K-1] when K>0, else 0.
// - High part: sum[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K] + ci, exact with full ripple carry.
//   K=0 gives an exact WIDTH+1 add.
// - Stage 1 registers: low sum bits, ci, high operands, K.
//   Stage 2 registers: the full out_sum.
// - Latency 2 cycles from accept to out_valid; throughput 1 beat/cycle.
// - Flow control: a stage loads when its register is empty or is being drained in the same cycle.
//   - in_ready = !s1_v | !s2_v | out_ready (combinational from out_ready; no skid buffer).
//   - With out_ready low, the pipeline holds 2 beats, then in_ready drops.
//   - Data is never lost or reordered.
// - Stability: out_sum and out_valid hold while out_valid & !out_ready.
// - Simultaneous accept and drain: both happen in the same cycle; occupancy is unchanged.
// - Reset mid-operation: the pipeline empties immediately. The first accept after release
//   appears 2 cycles later.
// CONFIGURATION
// - `define APX_ERR_MON_EN: stage 1 also computes the exact a+b, which is carried to stage 2.
//   On each output handshake:
//   - if out_sum != exact, err_cnt increments, saturating at all-ones;
//   - |exact - out_sum| is added to err_acc, saturating.
//   - err_clr zeroes both counters; if err_clr coincides with a handshake, the clear wins
//     and that beat is not counted.
// - Without the macro: no exact path is built; err_cnt and err_acc are tied to 0 and
//   err_clr is ignored.
// TESTING
// 1) K=8: a=0x1234, b=0x0F0F -> out_sum=0x0213F two cycles after accept;
//    with monitor: err_cnt=1, err_acc=4.
// 2) K=0: a=0xFFFF, b=0x0001 -> out_sum=0x10000 (exact).
//    K=12 with APX_MAX=8 -> behaves as K=8.
// 3) K=8: a=0x0080, b=0x0080 -> out_sum=0x0010F (exact 0x00100); err_acc grows by 15.
// 4) Backpressure: out_ready=0 while 3 beats are offered -> 2 accepted, then in_ready=0.
//    Raise out_ready -> all 3 emerge in order, 1 per cycle.
// 5) Assert rst with 2 beats in flight -> out_valid=0 and out_sum=0 immediately.
//    Post-reset beat a=1, b=2, K=0 -> 0x00003 after 2 cycles.
// 6) Monitor: 10 mismatching results -> err_cnt=10. Pulse err_clr during an 11th handshake
//    -> err_cnt=0. Without APX_ERR_MON_EN -> err_cnt=0 throughout.

Source files
------------

// File: rtl/approx_adder_pipe_if.sv
// Valid/ready stream bundle for approx_adder_pipe: operand beat in, sum beat out.
// The master side drives operands and accepts results; the slave side is the adder.
interface approx_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int KW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [KW-1:0]    apx_k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  modport master (
    output in_valid, in_a, in_b, apx_k, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, apx_k, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined approximate adder: fixed-ones / OR-chain low part, exact high part.
// Optional error monitor enabled with `define APX_ERR_MON_EN.
module approx_adder_pipe #(
  parameter int WIDTH     = 16,
  parameter int APX_MAX   = 8,
  parameter int KW        = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_adder_pipe_if.slave   bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ERR_CNT_W-1:0] err_acc
);
  localparam int            SW    = WIDTH + 1;
  localparam logic [KW-1:0] K_MAX = KW'(APX_MAX);

  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s1_load, s2_load, accept;

  // A stage loads when it is empty or its content leaves in the same cycle.
  assign s2_load       = !s2_v_q | bus.out_ready;
  assign s1_load       = !s1_v_q | s2_load;
  assign accept        = bus.in_valid & s1_load;
  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_v_q;
  assign s1_v_d        = s1_load ? accept : s1_v_q;
  assign s2_v_d        = s2_load ? s1_v_q : s2_v_q;

  logic [KW-1:0]      k_d;
  logic [APX_MAX-1:0] gen, chain, low_d;
  logic               ci_d;
  logic [WIDTH-1:0]   hi_a_d, hi_b_d;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    logic cin;
    k_d    = (bus.apx_k > K_MAX) ? K_MAX : bus.apx_k;
    gen    = bus.in_a[APX_MAX-1:0] & bus.in_b[APX_MAX-1:0];
    chain  = gen << 1;
    low_d  = '0;
    ci_d   = 1'b0;
    cin    = 1'b0;
    for (int i = 0; i < APX_MAX; i++) begin
      // The OR-chain carry starts fresh at bit F = K>>1.
      cin = chain[i] & (i > int'(k_d >> 1));
      if (i < int'(k_d)) begin
        if (i < int'(k_d >> 1))
          low_d[i] = 1'b1;
        else if (i == int'(k_d) - 1)
          low_d[i] = cin | (bus.in_a[i] ^ bus.in_b[i]);
        else
          low_d[i] = bus.in_a[i] | bus.in_b[i] | cin;
      end
      if (i == int'(k_d) - 1) ci_d = gen[i];
    end
    hi_a_d = bus.in_a >> k_d;
    hi_b_d = bus.in_b >> k_d;
  end

  logic [APX_MAX-1:0] s1_low_q;
  logic               s1_ci_q;
  logic [WIDTH-1:0]   s1_hi_a_q, s1_hi_b_q;
  logic [KW-1:0]      s1_k_q;
  logic [SW-1:0]      out_sum_q, out_sum_d;

  // NOTE: the datapath registers are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_low_q  <= low_d;
      s1_ci_q   <= ci_d;
      s1_hi_a_q <= hi_a_d;
      s1_hi_b_q <= hi_b_d;
      s1_k_q    <= k_d;
    end
  end

  assign out_sum_d = ((SW'(s1_hi_a_q) + SW'(s1_hi_b_q) + SW'(s1_ci_q)) << s1_k_q)
                   | SW'(s1_low_q);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      out_sum_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (s2_load && s1_v_q) out_sum_q <= out_sum_d;
    end
  end

  assign bus.out_sum = out_sum_q;

`ifdef APX_ERR_MON_EN
  localparam int                   AW      = ERR_CNT_W + SW;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0]        s1_exact_q, s2_exact_q, err_diff;
  logic [AW-1:0]        acc_sum;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, err_acc_q, err_acc_d;
  logic                 out_hs;

  always_ff @(posedge clk) begin
    if (accept) s1_exact_q <= SW'(bus.in_a) + SW'(bus.in_b);
    if (s2_load && s1_v_q) s2_exact_q <= s1_exact_q;
  end

  assign out_hs   = s2_v_q & bus.out_ready;
  assign err_diff = (s2_exact_q >= out_sum_q) ? s2_exact_q - out_sum_q
                                              : out_sum_q - s2_exact_q;
  assign acc_sum  = AW'(err_acc_q) + AW'(err_diff);

  // A clear coinciding with a handshake wins; that beat is not counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_acc_d = err_acc_q;
    if (err_clr) begin
      err_cnt_d = '0;
      err_acc_d = '0;
    end else if (out_hs) begin
      if (err_diff != '0 && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      err_acc_d = (acc_sum > AW'(CNT_MAX)) ? CNT_MAX : acc_sum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_acc_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_acc_q <= err_acc_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_acc = err_acc_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
  assign err_acc        = '0;
`endif
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Randomized and directed bench for approx_adder_pipe against a queue-based arithmetic model.
// Honours `define APX_ERR_MON_EN for the error-monitor expectations.
module tb_approx_adder_pipe;
  localparam int WIDTH   = 16;
  localparam int APX_MAX = 8;
  localparam int KW      = 4;
  localparam int CW      = 16;
  localparam int SAT     = 65535;
`ifdef APX_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_cnt, err_acc;

  approx_adder_pipe_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

  approx_adder_pipe #(.WIDTH(WIDTH), .APX_MAX(APX_MAX), .KW(KW), .ERR_CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_clr (err_clr),
    .err_cnt (err_cnt),
    .err_acc (err_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] sum;
    int          exact;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_hs = 0;
  int          mon_cnt = 0;
  int          mon_acc = 0;
  bit          last_acc;
  bit          prev_stall = 1'b0;
  logic [16:0] prev_sum;
  logic [16:0] last_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Approximate sum straight from the bit rules, using plain integer arithmetic.
  function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b,
                                            input int kraw);
    int k, f, low, hi, ci, carry, bit_v;
    k   = (kraw > APX_MAX) ? APX_MAX : kraw;
    f   = k / 2;
    low = 0;
    for (int i = 0; i < k; i++) begin
      if (i < f) bit_v = 1;
      else begin
        carry = (i > f) ? int'(a[i-1] & b[i-1]) : 0;
        if (i == k - 1) bit_v = carry | int'(a[i] ^ b[i]);
        else            bit_v = int'(a[i] | b[i]) | carry;
      end
      low = low | (bit_v << i);
    end
    ci = (k > 0) ? int'(a[k-1] & b[k-1]) : 0;
    hi = int'(a >> k) + int'(b >> k) + ci;
    return 17'((hi << k) | low);
  endfunction

  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] k, input logic ordy, input logic clr);
    exp_t e;
    bit   hs;
    int   d;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.apx_k     = k;
    bus.out_ready = ordy;
    err_clr       = clr;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_sum", 32'(bus.out_sum), 32'(prev_sum));
    end
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0 && q[0].cyc + 2 <= cyc));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || ordy));
    check("err_cnt", 32'(err_cnt), 32'(mon_cnt));
    check("err_acc", 32'(err_acc), 32'(mon_acc));
    last_acc = v && bus.in_ready;
    hs = 1'b0;
    if (bus.out_valid && ordy && q.size() > 0) begin
      e = q.pop_front();
      check("out_sum", 32'(bus.out_sum), 32'(e.sum));
      last_out = bus.out_sum;
      hs = 1'b1;
      n_hs++;
    end
    if (MON) begin
      if (clr) begin
        mon_cnt = 0;
        mon_acc = 0;
      end else if (hs) begin
        d = (e.exact > int'(e.sum)) ? e.exact - int'(e.sum) : int'(e.sum) - e.exact;
        if (d != 0 && mon_cnt < SAT) mon_cnt++;
        mon_acc = (mon_acc + d > SAT) ? SAT : mon_acc + d;
      end
    end
    if (last_acc) q.push_back('{model_sum(a, b, int'(k)), int'(a) + int'(b), cyc});
    prev_stall = bus.out_valid && !ordy;
    prev_sum   = bus.out_sum;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    #1;
    cyc++;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum", 32'(bus.out_sum), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_acc", 32'(err_acc), 0);
    q.delete();
    mon_cnt    = 0;
    mon_acc    = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int hs0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.apx_k     = '0;
    bus.out_ready = 1'b0;
    do_reset();

    // Model pins, hand-computed from the bit rules.
    check("pin_k8", 32'(model_sum(16'h1234, 16'h0F0F, 8)), 32'h0213F);
    check("pin_k0", 32'(model_sum(16'hFFFF, 16'h0001, 0)), 32'h10000);
    check("pin_k12", 32'(model_sum(16'h1234, 16'h0F0F, 12)), 32'h0213F);
    check("pin_carry", 32'(model_sum(16'h0080, 16'h0080, 8)), 32'h0010F);

    // K=8 approximate beat, two cycles of latency.
    last_out = '1;
    cycle(1'b1, 16'h1234, 16'h0F0F, 4'd8, 1'b1, 1'b0);
    idle(2);
    check("t1_sum", 32'(last_out), 32'h0213F);
    idle(1);
    check("t1_err_cnt", 32'(err_cnt), MON ? 1 : 0);
    check("t1_err_acc", 32'(err_acc), MON ? 4 : 0);

    // Exact add with K=0, and clamping of K=12 to 8.
    last_out = '1;
    cycle(1'b1, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 16'h1234, 16'h0F0F, 4'd12, 1'b1, 1'b0);
    idle(1);
    check("t2_exact", 32'(last_out), 32'h10000);
    idle(1);
    check("t2_clamp", 32'(last_out), 32'h0213F);

    // Carry into the high part from bit K-1.
    last_out = '1;
    cycle(1'b1, 16'h0080, 16'h0080, 4'd8, 1'b1, 1'b0);
    idle(2);
    check("t3_sum", 32'(last_out), 32'h0010F);
    idle(1);
    check("t3_err_cnt", 32'(err_cnt), MON ? 3 : 0);
    check("t3_err_acc", 32'(err_acc), MON ? 23 : 0);

    // Backpressure: two beats fill the pipe, the third waits, then all drain in order.
    cycle(1'b1, 16'h1111, 16'h0101, 4'd4, 1'b0, 1'b0);
    check("bp_acc1", 32'(last_acc), 1);
    cycle(1'b1, 16'h2222, 16'h0202, 4'd5, 1'b0, 1'b0);
    check("bp_acc2", 32'(last_acc), 1);
    cycle(1'b1, 16'h3333, 16'h0303, 4'd6, 1'b0, 1'b0);
    check("bp_acc3", 32'(last_acc), 0);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    hs0 = n_hs;
    cycle(1'b1, 16'h3333, 16'h0303, 4'd6, 1'b1, 1'b0);
    check("bp_acc3_retry", 32'(last_acc), 1);
    idle(2);
    check("bp_burst", 32'(n_hs - hs0), 3);

    // Reset with two beats in flight, then a fresh beat.
    cycle(1'b1, 16'hAAAA, 16'h5555, 4'd3, 1'b1, 1'b0);
    cycle(1'b1, 16'h0F0F, 16'hF0F0, 4'd7, 1'b1, 1'b0);
    do_reset();
    last_out = '1;
    cycle(1'b1, 16'h0001, 16'h0002, 4'd0, 1'b1, 1'b0);
    idle(2);
    check("t5_post_reset", 32'(last_out), 32'h00003);

    // Monitor: ten mismatching beats, then a clear during the eleventh handshake.
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h0080, 16'h0080, 4'd8, 1'b1, 1'b0);
    idle(3);
    check("t6_err_cnt10", 32'(err_cnt), MON ? 10 : 0);
    cycle(1'b1, 16'h0080, 16'h0080, 4'd8, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    hs0 = n_hs;
    cycle(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1);
    check("t6_clr_hs", 32'(n_hs - hs0), 1);
    idle(1);
    check("t6_err_cnt_clr", 32'(err_cnt), 0);
    check("t6_err_acc_clr", 32'(err_acc), 0);

    // Random traffic with random stalls and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    check("drain_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
